// File: rtl/program_loader_pkg.sv
// loader_pkg: shared types and defaults for the program loader.
//   state_t              - loader FSM state encoding
//   DEF_DEBOUNCE_CYCLES  - default button stability window in clock cycles
//   DEF_HOLD_CYCLES      - default CPU reset hold after leaving program mode
package loader_pkg;

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_RUN     = 2'd1,
    ST_LOAD    = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd50000;
  localparam int unsigned DEF_HOLD_CYCLES     = 32'd8;

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: instruction-memory write bus.
//   mem_we    - single-cycle write strobe
//   mem_addr  - write address (holds last value while mem_we is low)
//   mem_wdata - write data byte
// master modport drives the bus (loader), slave modport receives it (memory).
interface program_loader_if #(
  parameter int unsigned ADDR_W = 32'd5
);

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);

endinterface

// File: rtl/program_loader_button_debounce.sv
// button_debounce: synchronizes an active-low push button, accepts a new level
// only after it has been stable for DEBOUNCE_CYCLES cycles, and flags presses.
//   clock, reset_N - system clock, asynchronous active-low reset
//   btn_N          - raw active-low button (asynchronous)
//   level          - debounced button level (1 = released)
//   press_pulse    - one-cycle pulse when the debounced level falls 1 -> 0
module button_debounce
  import loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_N,
  input  logic btn_N,
  output logic level,
  output logic press_pulse
);

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 32'd1);

  logic        sync_m_q;
  logic        sync_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        level_q;
  logic        level_d;
  logic        pulse_q;
  logic        pulse_d;

  // Two-flop synchronizer for the raw button; idles released.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      sync_m_q <= 1'b1;
      sync_q   <= 1'b1;
    end else begin
      sync_m_q <= btn_N;
      sync_q   <= sync_m_q;
    end
  end

  // Stability counter runs only while the synchronized input disagrees with
  // the accepted level; any return to agreement restarts the window.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync_q;
        cnt_d   = 16'd0;
        pulse_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      cnt_d = 16'd0;
    end
  end

  // Debounce state and registered press pulse.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      cnt_q   <= 16'd0;
      level_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level       = level_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/program_loader.sv
// program_loader: captures switch bytes on debounced button presses while in
// program mode and writes them to instruction memory from address 0 upward.
// Holds the CPU in reset while loading and for HOLD_CYCLES after leaving it.
//   clock, reset_N - system clock, asynchronous active-low reset
//   p_clock_N      - raw program-clock push button (active-low)
//   mode           - raw mode switch, 1 = program, 0 = run
//   io_in          - raw switch byte
//   mem            - instruction-memory write bus (master side)
//   load_count     - bytes written this session, saturates at DEPTH
//   cpu_hold       - 1 = keep CPU in reset
//   loading        - 1 while loading or full
//   overflow       - sticky: press seen while full; cleared on entering LOAD
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32'd5,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset_N,
  input  logic                 p_clock_N,
  input  logic                 mode,
  input  logic [7:0]           io_in,
  program_loader_if.master     mem,
  output logic [ADDR_W:0]      load_count,
  output logic                 cpu_hold,
  output logic                 loading,
  output logic                 overflow
);

  localparam logic [7:0]        HOLD_LAST = 8'(HOLD_CYCLES - 32'd1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic              mode_m_q;
  logic              mode_s_q;
  logic              press_pulse_s;
  logic              level_s;

  state_t            state_q,      state_d;
  logic [7:0]        hold_cnt_q,   hold_cnt_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              overflow_q,   overflow_d;
  logic              we_q,         we_d;
  logic [ADDR_W-1:0] maddr_q,      maddr_d;
  logic [7:0]        wdata_q,      wdata_d;
  logic              cpu_hold_q,   cpu_hold_d;
  logic              loading_q,    loading_d;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock       (clock),
    .reset_N     (reset_N),
    .btn_N       (p_clock_N),
    .level       (level_s),
    .press_pulse (press_pulse_s)
  );

  // Two-flop synchronizer for the mode switch; resets to run.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      mode_m_q <= 1'b0;
      mode_s_q <= 1'b0;
    end else begin
      mode_m_q <= mode;
      mode_s_q <= mode_s_q ^ (mode_s_q ^ mode_m_q);
    end
  end

  // Loader FSM next-state and datapath; mode changes take priority over presses.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    addr_d       = addr_q;
    load_count_d = load_count_q;
    overflow_d   = overflow_q;
    we_d         = 1'b0;
    maddr_d      = maddr_q;
    wdata_d      = wdata_q;
    case (state_q)
      ST_RELEASE: begin
        if (mode_s_q) begin
          state_d      = ST_LOAD;
          addr_d       = {ADDR_W{1'b0}};
          load_count_d = {(ADDR_W+1){1'b0}};
          overflow_d   = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (mode_s_q) begin
          state_d      = ST_LOAD;
          addr_d       = {ADDR_W{1'b0}};
          load_count_d = {(ADDR_W+1){1'b0}};
          overflow_d   = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (!mode_s_q) begin
          state_d    = ST_RELEASE;
          hold_cnt_d = 8'd0;
        end else if (press_pulse_s) begin
          we_d         = 1'b1;
          maddr_d      = addr_q;
          wdata_d      = io_in;
          addr_d       = addr_q + ADDR_ONE;
          load_count_d = load_count_q + CNT_ONE;
          if (addr_q == ADDR_LAST) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FULL: begin
        if (!mode_s_q) begin
          state_d    = ST_RELEASE;
          hold_cnt_d = 8'd0;
        end else if (press_pulse_s) begin
          overflow_d = 1'b1;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d    = ST_RELEASE;
        hold_cnt_d = 8'd0;
      end
    endcase
    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    cpu_hold_d = (state_d != ST_RUN);
    loading_d  = (state_d == ST_LOAD) || (state_d == ST_FULL);
  end

  // Loader state, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q      <= ST_RELEASE;
      hold_cnt_q   <= 8'd0;
      addr_q       <= {ADDR_W{1'b0}};
      load_count_q <= {(ADDR_W+1){1'b0}};
      overflow_q   <= 1'b0;
      we_q         <= 1'b0;
      maddr_q      <= {ADDR_W{1'b0}};
      wdata_q      <= 8'd0;
      cpu_hold_q   <= 1'b1;
      loading_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      addr_q       <= addr_d;
      load_count_q <= load_count_d;
      overflow_q   <= overflow_d;
      we_q         <= we_d;
      maddr_q      <= maddr_d;
      wdata_q      <= wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      loading_q    <= loading_d;
    end
  end

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = wdata_q;
  assign load_count    = load_count_q;
  assign cpu_hold      = cpu_hold_q;
  assign loading       = loading_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader (ADDR_W=5, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8).
// Stimulus pushes expected {addr,data} writes into a queue; a monitor pops
// and compares each time the DUT strobes mem_we.
module tb_program_loader;

  logic       clock;
  logic       reset_N;
  logic       p_clock_N;
  logic       mode;
  logic [7:0] io_in;
  logic [5:0] load_count;
  logic       cpu_hold;
  logic       loading;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  logic [12:0] sb[$];

  program_loader_if #(.ADDR_W(5)) mem_if ();

  program_loader #(
    .ADDR_W          (5),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8)
  ) dut (
    .clock      (clock),
    .reset_N    (reset_N),
    .p_clock_N  (p_clock_N),
    .mode       (mode),
    .io_in      (io_in),
    .mem        (mem_if.master),
    .load_count (load_count),
    .cpu_hold   (cpu_hold),
    .loading    (loading),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_mem_we",     {31'd0, mem_if.mem_we}, 32'd0);
    check("rst_mem_addr",   {27'd0, mem_if.mem_addr}, 32'd0);
    check("rst_mem_wdata",  {24'd0, mem_if.mem_wdata}, 32'd0);
    check("rst_load_count", {26'd0, load_count}, 32'd0);
    check("rst_cpu_hold",   {31'd0, cpu_hold}, 32'd1);
    check("rst_loading",    {31'd0, loading}, 32'd0);
    check("rst_overflow",   {31'd0, overflow}, 32'd0);
  endtask

  // Clean press: 12 cycles low, 12 cycles high; ends on a negedge.
  task automatic press(input logic [7:0] b, input bit exp_wr, input logic [4:0] exp_addr);
    if (exp_wr) sb.push_back({exp_addr, b});
    io_in     = b;
    p_clock_N = 1'b0;
    repeat (12) @(negedge clock);
    p_clock_N = 1'b1;
    repeat (12) @(negedge clock);
  endtask

  // Monitor: every strobe must match the oldest expected write.
  initial begin
    logic        prev_we;
    logic [12:0] exp_e;
    prev_we = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_if.mem_we === 1'b1) begin
        check("we_not_consecutive", {31'd0, prev_we}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                   mem_if.mem_addr, mem_if.mem_wdata);
        end else begin
          exp_e = sb.pop_front();
          check("write_addr_data", {19'd0, mem_if.mem_addr, mem_if.mem_wdata}, {19'd0, exp_e});
        end
      end
      prev_we = (mem_if.mem_we === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2 [5];
    t2 = '{8'h81, 8'h10, 8'h06, 8'h46, 8'hDA};

    reset_N   = 1'b0;
    p_clock_N = 1'b1;
    mode      = 1'b0;
    io_in     = 8'h00;
    repeat (3) @(negedge clock);
    check_reset_values();

    // Reset release in run mode: hold for exactly 8 cycles.
    reset_N = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      check("hold_after_reset", {31'd0, cpu_hold}, (i < 8) ? 32'd1 : 32'd0);
    end
    repeat (3) @(negedge clock);
    check("run_hold_low", {31'd0, cpu_hold}, 32'd0);
    check("run_not_loading", {31'd0, loading}, 32'd0);

    // Five clean bytes.
    mode = 1'b1;
    repeat (4) @(negedge clock);
    check("load_entry_loading", {31'd0, loading}, 32'd1);
    check("load_entry_count", {26'd0, load_count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      press(t2[i], 1'b1, 5'(i));
      check("load_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    end
    check("five_count", {26'd0, load_count}, 32'd5);
    check("five_drained", sb.size(), 32'd0);

    // Bouncy press and bouncy release: exactly one write.
    sb.push_back({5'd5, 8'h3C});
    io_in = 8'h3C;
    repeat (2) begin
      p_clock_N = 1'b0;
      repeat (3) @(negedge clock);
      p_clock_N = 1'b1;
      repeat (3) @(negedge clock);
    end
    p_clock_N = 1'b0;
    repeat (12) @(negedge clock);
    p_clock_N = 1'b1;
    repeat (3) @(negedge clock);
    p_clock_N = 1'b0;
    repeat (3) @(negedge clock);
    p_clock_N = 1'b1;
    repeat (12) @(negedge clock);
    check("bounce_count", {26'd0, load_count}, 32'd6);
    check("bounce_drained", sb.size(), 32'd0);

    // New session: 33 presses fill 32 bytes and overflow once.
    mode = 1'b0;
    repeat (4) @(negedge clock);
    mode = 1'b1;
    repeat (4) @(negedge clock);
    check("session_restart_count", {26'd0, load_count}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      press(8'(i * 5 + 3), 1'b1, 5'(i));
    end
    check("full_count", {26'd0, load_count}, 32'd32);
    check("full_no_overflow_yet", {31'd0, overflow}, 32'd0);
    check("full_loading", {31'd0, loading}, 32'd1);
    press(8'hEE, 1'b0, 5'd0);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    check("full_count_sat", {26'd0, load_count}, 32'd32);
    check("full_drained", sb.size(), 32'd0);

    // Leave program mode: RELEASE entered on the 3rd edge, hold drops 8 later.
    mode = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clock);
      if (i == 2)  check("exit_loading_still", {31'd0, loading}, 32'd1);
      if (i == 3)  check("exit_loading_low", {31'd0, loading}, 32'd0);
      if (i == 10) check("exit_hold_still", {31'd0, cpu_hold}, 32'd1);
      if (i == 11) check("exit_hold_low", {31'd0, cpu_hold}, 32'd0);
    end
    check("overflow_sticky", {31'd0, overflow}, 32'd1);

    // Press pulse coincident with mode_s falling: mode wins, no write.
    mode = 1'b1;
    repeat (4) @(negedge clock);
    check("overflow_cleared", {31'd0, overflow}, 32'd0);
    press(8'h5A, 1'b1, 5'd0);
    check("pre_coincide_count", {26'd0, load_count}, 32'd1);
    io_in     = 8'hA5;
    p_clock_N = 1'b0;
    repeat (4) @(negedge clock);
    mode = 1'b0;
    repeat (12) @(negedge clock);
    p_clock_N = 1'b1;
    repeat (12) @(negedge clock);
    check("coincide_count", {26'd0, load_count}, 32'd1);
    check("coincide_loading", {31'd0, loading}, 32'd0);
    check("coincide_drained", sb.size(), 32'd0);

    // Reset mid-load after three bytes, then a fresh session.
    mode = 1'b1;
    repeat (4) @(negedge clock);
    press(8'h11, 1'b1, 5'd0);
    press(8'h22, 1'b1, 5'd1);
    press(8'h33, 1'b1, 5'd2);
    check("midload_count", {26'd0, load_count}, 32'd3);
    reset_N = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clock);
    reset_N = 1'b1;
    repeat (6) @(negedge clock);
    check("after_reset_loading", {31'd0, loading}, 32'd1);
    check("after_reset_count", {26'd0, load_count}, 32'd0);
    press(8'h77, 1'b1, 5'd0);
    check("after_reset_first", {26'd0, load_count}, 32'd1);
    check("final_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
